// File: rtl/timed_rr_arbiter.sv
// Round-robin arbiter with a per-ownership hold timeout and lockout of expired ports.
// Optional ARB_LOCK_EN adds a lock input that freezes the hold counter while held.
module timed_rr_arbiter #(
   parameter int NUM_PORTS = 3,
   parameter int TIMEOUT   = 10,
   parameter int CNT_W     = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [0:NUM_PORTS-1]         request,
`ifdef ARB_LOCK_EN
   input  logic                         lock,
`endif
   output logic [0:NUM_PORTS-1]         grant,
   output logic                         active,
   output logic [$clog2(NUM_PORTS)-1:0] owner,
   output logic [0:NUM_PORTS-1]         expired
);

   localparam int OW = $clog2(NUM_PORTS);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);
   localparam logic TO_EN = (TIMEOUT != 0);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [0:NUM_PORTS-1]   mask;
   logic [OW-1:0]          ptr;
   logic [0:NUM_PORTS-1]   eff;
   logic [OW-1:0]          pick;
   logic [OW-1:0]          pick_next;
   logic                   found;
   logic                   frozen;
   logic                   owner_req;
   logic                   timeout_hit;
   int                     idx;

`ifdef ARB_LOCK_EN
   assign frozen = lock;
`else
   assign frozen = 1'b0;
`endif

   assign eff         = request & ~mask;
   assign owner_req   = request[owner];
   assign timeout_hit = TO_EN && (cnt == CNT_TO) && !frozen;
   assign pick_next   = (int'(pick) == NUM_PORTS - 1) ? '0 : pick + 1'b1;

   // First effective request at or above the pointer, wrapping around.
   always_comb begin
      pick  = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
         if (!found && eff[idx]) begin
            found = 1'b1;
            pick  = OW'(idx);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         grant   <= '0;
         active  <= 1'b0;
         owner   <= '0;
         expired <= '0;
         cnt     <= '0;
         mask    <= '0;
         ptr     <= '0;
      end else begin
         expired <= '0;
         // A lockout lasts only until the port lets go of its request.
         mask    <= mask & request;
         case (state)
            IDLE: begin
               if (found) begin
                  grant       <= '0;
                  grant[pick] <= 1'b1;
                  owner       <= pick;
                  active      <= 1'b1;
                  cnt         <= CNT_W'(1);
                  ptr         <= pick_next;
                  state       <= BUSY;
               end
            end
            BUSY: begin
               if (!owner_req) begin
                  grant  <= '0;
                  active <= 1'b0;
                  cnt    <= '0;
                  state  <= IDLE;
               end else if (timeout_hit) begin
                  grant          <= '0;
                  active         <= 1'b0;
                  cnt            <= '0;
                  expired[owner] <= 1'b1;
                  mask[owner]    <= 1'b1;
                  state          <= IDLE;
               end else if (!frozen && cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
